// File: rtl/mux8_pkg.sv
// Shared types and helpers for the 8-way round-robin mux arbiter.
// The arbitration scan lives here so other blocks can reuse the same priority rule.
package mux8_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // Pick the first set request after last, wrapping modulo NREQ; last itself is checked last.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NREQ-1:0]  req,
        input logic [SEL_W-1:0] last
    );
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = last + SEL_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

endpackage

// File: rtl/mux_8to1.sv
// Team 8-to-1 mux, W bits wide; purely combinational.
module mux_8to1 #(
    parameter int W = 3
) (
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    input  logic [W-1:0] a3,
    input  logic [W-1:0] a4,
    input  logic [W-1:0] a5,
    input  logic [W-1:0] a6,
    input  logic [W-1:0] a7,
    input  logic [2:0]   sel,
    output logic [W-1:0] y
);

    // Select one of the eight inputs
    always_comb begin
        y = a0;
        case (sel)
            3'd0:    y = a0;
            3'd1:    y = a1;
            3'd2:    y = a2;
            3'd3:    y = a3;
            3'd4:    y = a4;
            3'd5:    y = a5;
            3'd6:    y = a6;
            3'd7:    y = a7;
            default: y = a0;
        endcase
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving an 8-to-1 mux select; each grant serves a bounded burst
// over a valid/ready channel, with one IDLE bubble between grants.
module mux8_rr_arbiter
    import mux8_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int DW        = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*DW-1:0]  data_i,
    input  logic                out_ready_i,
    output logic                out_valid_o,
    output logic [DW-1:0]       out_data_o,
    output logic [SEL_W-1:0]    sel_o,
    output logic [NREQ-1:0]     grant_o,
    output logic [NREQ-1:0]     ack_o,
    output logic                busy_o
);

    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);

    state_t           state_r, state_nxt_s;
    logic [SEL_W-1:0] sel_r, sel_nxt_s;
    logic [SEL_W-1:0] last_ptr_r, last_ptr_nxt_s;
    logic [3:0]       beat_cnt_r, beat_cnt_nxt_s;
    logic             req_sel_s;
    logic             xfer_s;

    assign req_sel_s = req_i[sel_r];
    assign xfer_s    = (state_r == SERVE) && req_sel_s && out_ready_i;
    assign sel_o     = sel_r;

    // State, select, priority pointer and beat counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            sel_r      <= 3'd0;
            last_ptr_r <= 3'd7;
            beat_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_nxt_s;
            sel_r      <= sel_nxt_s;
            last_ptr_r <= last_ptr_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

    // Next-state: arbitrate in IDLE, count beats and detect burst end or withdrawal in SERVE
    always_comb begin
        state_nxt_s    = state_r;
        sel_nxt_s      = sel_r;
        last_ptr_nxt_s = last_ptr_r;
        beat_cnt_nxt_s = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (req_i != 8'd0) begin
                    sel_nxt_s      = rr_pick(req_i, last_ptr_r);
                    beat_cnt_nxt_s = 4'd0;
                    state_nxt_s    = SERVE;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            SERVE: begin
                // A transfer implies req_sel_s, so last beat and withdrawal never both fire here
                if (xfer_s) begin
                    beat_cnt_nxt_s = beat_cnt_r + 4'd1;
                    if (beat_cnt_r == BURST_LAST) begin
                        state_nxt_s    = IDLE;
                        last_ptr_nxt_s = sel_r;
                    end else begin
                        state_nxt_s    = SERVE;
                    end
                end else if (!req_sel_s) begin
                    state_nxt_s    = IDLE;
                    last_ptr_nxt_s = sel_r;
                end else begin
                    state_nxt_s    = SERVE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake, grant and ack outputs derived from the registered state and select
    always_comb begin
        out_valid_o = 1'b0;
        grant_o     = 8'd0;
        ack_o       = 8'd0;
        busy_o      = 1'b0;
        if (state_r == SERVE) begin
            busy_o      = 1'b1;
            grant_o     = 8'd1 << sel_r;
            out_valid_o = req_sel_s;
            if (xfer_s) begin
                ack_o = 8'd1 << sel_r;
            end else begin
                ack_o = 8'd0;
            end
        end else begin
            busy_o = 1'b0;
        end
    end

    mux_8to1 #(.W(DW)) u_mux (
        .a0  (data_i[0*DW +: DW]),
        .a1  (data_i[1*DW +: DW]),
        .a2  (data_i[2*DW +: DW]),
        .a3  (data_i[3*DW +: DW]),
        .a4  (data_i[4*DW +: DW]),
        .a5  (data_i[5*DW +: DW]),
        .a6  (data_i[6*DW +: DW]),
        .a7  (data_i[7*DW +: DW]),
        .sel (sel_r),
        .y   (out_data_o)
    );

endmodule
